// File: rtl/des_pkg.sv
// DES constant tables, FSM state type and the permutation/key-rotation helpers
// shared by the iterative core and its S-box lookup.
package des_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0, LOAD = 4'd1, KEYGEN = 4'd2, ROUND_KEY = 4'd3, EXPAND = 4'd4,
        SBOX = 4'd5, PERM = 4'd6, FINAL = 4'd7, DONE = 4'd8
    } state_t;

    localparam logic [4:0] ROUNDS = 5'd16;
    // Rounds whose key rotation is a single position (1, 2, 9, 16); bit 0 unused.
    localparam logic [16:0] SHIFT_ONE = 17'b1_0000_0010_0000_0110;

    localparam int IP_T [64] = '{
        58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4, 62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
        57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3, 61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
    localparam int FP_T [64] = '{
        40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31, 38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
        36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27, 34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
    localparam int E_T [48] = '{
        32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
        16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29, 28,29,30,31,32,1};
    localparam int P_T [32] = '{
        16,7,20,21,29,12,28,17, 1,15,23,26,5,18,31,10, 2,8,24,14,32,27,3,9, 19,13,30,6,22,11,4,25};
    localparam int PC1_T [56] = '{
        57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27, 19,11,3,60,52,44,36,
        63,55,47,39,31,23,15, 7,62,54,46,38,30,22, 14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    localparam int PC2_T [48] = '{
        14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
        41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};

    // Row-major: entry index is row*16 + column.
    localparam int S_T [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}};

    // Sources are left-aligned in 64 bits so DES position p is always src[64-p].
    function automatic logic pick(input logic [63:0] src, input int pos);
        return src[6'(64 - pos)];
    endfunction

    function automatic logic [63:0] perm_ip(input logic [63:0] b);
        logic [63:0] o = '0;
        for (int i = 0; i < 64; i++) o = {o[62:0], pick(b, IP_T[i])};
        return o;
    endfunction

    function automatic logic [63:0] perm_fp(input logic [63:0] b);
        logic [63:0] o = '0;
        for (int i = 0; i < 64; i++) o = {o[62:0], pick(b, FP_T[i])};
        return o;
    endfunction

    function automatic logic [47:0] expand_e(input logic [31:0] r);
        logic [47:0] o = '0;
        for (int i = 0; i < 48; i++) o = {o[46:0], pick({r, 32'd0}, E_T[i])};
        return o;
    endfunction

    function automatic logic [31:0] perm_p(input logic [31:0] v);
        logic [31:0] o = '0;
        for (int i = 0; i < 32; i++) o = {o[30:0], pick({v, 32'd0}, P_T[i])};
        return o;
    endfunction

    function automatic logic [55:0] perm_pc1(input logic [63:0] k);
        logic [55:0] o = '0;
        for (int i = 0; i < 56; i++) o = {o[54:0], pick(k, PC1_T[i])};
        return o;
    endfunction

    function automatic logic [47:0] perm_pc2(input logic [55:0] cd);
        logic [47:0] o = '0;
        for (int i = 0; i < 48; i++) o = {o[46:0], pick({cd, 8'd0}, PC2_T[i])};
        return o;
    endfunction

    // Decrypt walks the schedule backwards from C16=C0: rotate right by the
    // forward amount of round 18-r, which lands on the same one-shift set.
    function automatic logic [27:0] rot28(input logic [27:0] v, input logic [4:0] rnd,
                                          input logic enc);
        logic [55:0] t;
        int          amt;
        if (enc)              amt = SHIFT_ONE[rnd] ? 1 : 2;
        else if (rnd == 5'd1) amt = 0;
        else                  amt = SHIFT_ONE[rnd] ? 27 : 26;
        t = {v, v} << amt;
        return t[55:28];
    endfunction

endpackage

// File: rtl/des_iterative_core_sbox.sv
// Combinational lookup of all eight DES S-boxes: 48-bit mixed word in, 32 bits out.
module des_sbox
    import des_pkg::*;
(
    input  logic [47:0] x,
    output logic [31:0] s
);
    for (genvar g = 0; g < 8; g++) begin : g_box
        logic [5:0] b6;
        assign b6 = x[47-6*g -: 6];
        // Outer bits select the row, inner four the column.
        assign s[31-4*g -: 4] = 4'(S_T[g][{b6[5], b6[0], b6[4:1]}]);
    end
endmodule

// File: rtl/des_iterative_core.sv
// Iterative single-block DES engine; each Feistel round spends four clocks
// (key rotate, expand/mix, S-box, swap) under a two-process FSM.
module des_iterative_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        encrypt,
    input  logic [63:0] data_in,
    input  logic [63:0] key,
    output logic [63:0] data_out,
    output logic        done,
    output logic        error
);
    import des_pkg::*;

    state_t      state, state_next;
    logic [4:0]  round_count;
    logic [31:0] left, right, s, sbox_out, feistel_out;
    logic [27:0] c_reg, d_reg, c_rot, d_rot;
    logic [47:0] subkey, x;
    logic [63:0] block_q, key_q;
    logic        enc_q, busy;

    des_sbox u_sbox (.x(x), .s(sbox_out));

    assign feistel_out = perm_p(s);
    assign c_rot       = rot28(c_reg, round_count, enc_q);
    assign d_rot       = rot28(d_reg, round_count, enc_q);
    assign busy        = (state >= LOAD) && (state <= FINAL);
    assign done        = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: if (start) state_next = LOAD;
            LOAD:       state_next = KEYGEN;
            KEYGEN:     state_next = ROUND_KEY;
            ROUND_KEY:  state_next = EXPAND;
            EXPAND:     state_next = SBOX;
            SBOX:       state_next = PERM;
            PERM:       state_next = (round_count < ROUNDS) ? ROUND_KEY : FINAL;
            FINAL:      state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_count <= '0;
            left        <= '0;
            right       <= '0;
            c_reg       <= '0;
            d_reg       <= '0;
            subkey      <= '0;
            x           <= '0;
            s           <= '0;
            data_out    <= '0;
            error       <= 1'b0;
            enc_q       <= 1'b0;
            block_q     <= '0;
            key_q       <= '0;
        end else begin
            // A start while busy is flagged but never disturbs the running block.
            error <= start && busy;
            case (state)
                IDLE, DONE: if (start) begin
                    enc_q   <= encrypt;
                    block_q <= data_in;
                    key_q   <= key;
                end
                LOAD:      {left, right} <= perm_ip(block_q);
                KEYGEN: begin
                    {c_reg, d_reg} <= perm_pc1(key_q);
                    round_count    <= 5'd1;
                end
                ROUND_KEY: begin
                    c_reg  <= c_rot;
                    d_reg  <= d_rot;
                    subkey <= perm_pc2({c_rot, d_rot});
                end
                EXPAND:    x <= expand_e(right) ^ subkey;
                SBOX:      s <= sbox_out;
                PERM: begin
                    left  <= right;
                    right <= left ^ feistel_out;
                    if (round_count < ROUNDS) round_count <= round_count + 5'd1;
                end
                FINAL:     data_out <= perm_fp({right, left});
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_des_iterative_core.sv
// Directed + randomized bench for the iterative DES core against a textbook DES model.
module tb_des_iterative_core;
    import des_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, encrypt;
    logic [63:0] data_in, key, data_out;
    logic        done, error;

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;

    localparam logic [63:0] K1  = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT1 = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT1 = 64'h85E813540F0AB405;
    localparam logic [63:0] K2  = 64'h0E329232EA6D0D73;
    localparam logic [63:0] PT2 = 64'h8787878787878787;

    des_iterative_core dut (
        .clk(clk), .rst(rst), .start(start), .encrypt(encrypt), .data_in(data_in),
        .key(key), .data_out(data_out), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Full-schedule DES: all sixteen subkeys first, decrypt simply walks them backwards.
    function automatic logic [63:0] des_ref(input logic [63:0] k, input logic [63:0] blk,
                                            input bit enc);
        logic [27:0] c, d;
        logic [55:0] cd;
        logic [47:0] ks [16];
        logic [47:0] xx, kk;
        logic [63:0] ipb, pre, res;
        logic [31:0] l, r, t, f, sv;
        logic [5:0]  six;
        int          sched [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
        for (int i = 0; i < 56; i++) cd[6'(55-i)] = k[6'(64 - PC1_T[i])];
        c = cd[55:28];
        d = cd[27:0];
        for (int n = 0; n < 16; n++) begin
            for (int j = 0; j < sched[n]; j++) begin
                c = {c[26:0], c[27]};
                d = {d[26:0], d[27]};
            end
            cd = {c, d};
            for (int i = 0; i < 48; i++) ks[n][6'(47-i)] = cd[6'(56 - PC2_T[i])];
        end
        for (int i = 0; i < 64; i++) ipb[6'(63-i)] = blk[6'(64 - IP_T[i])];
        l = ipb[63:32];
        r = ipb[31:0];
        for (int n = 0; n < 16; n++) begin
            kk = enc ? ks[n] : ks[15-n];
            for (int i = 0; i < 48; i++) xx[6'(47-i)] = r[5'(32 - E_T[i])];
            xx = xx ^ kk;
            for (int b = 0; b < 8; b++) begin
                six = xx[47-6*b -: 6];
                sv[31-4*b -: 4] = 4'(S_T[b][{six[5], six[0], six[4:1]}]);
            end
            for (int i = 0; i < 32; i++) f[5'(31-i)] = sv[5'(32 - P_T[i])];
            t = r;
            r = l ^ f;
            l = t;
        end
        pre = {r, l};
        for (int i = 0; i < 64; i++) res[6'(63-i)] = pre[6'(64 - FP_T[i])];
        return res;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Leaves the bench #1 after the sampling edge (edge 0) with inputs scrambled.
    task automatic launch(input bit enc, input logic [63:0] din, input logic [63:0] k);
        @(negedge clk);
        encrypt = enc;
        data_in = din;
        key     = k;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        encrypt = ~enc;
        data_in = {$urandom, $urandom};
        key     = {$urandom, $urandom};
        edge_n  = 0;
    endtask

    task automatic finish_op(input string tag, input logic [63:0] exp);
        while (!done && edge_n < 200) step();
        chk({tag, " latency"}, 64'(edge_n), 64'd67);
        chk({tag, " data"}, data_out, exp);
    endtask

    initial begin
        logic [63:0] rk, rp, rc;
        bit          re;

        rst = 1'b1; start = 1'b0; encrypt = 1'b0; data_in = '0; key = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst done", 64'(done), 64'd0);
        chk("rst error", 64'(error), 64'd0);
        chk("rst data_out", data_out, 64'd0);
        chk("rst state", 64'(dut.state), 64'd0);
        chk("rst round_count", 64'(dut.round_count), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Known-answer vector with internal probes through round 1.
        launch(1'b1, PT1, K1);
        step();
        chk("ip left", 64'(dut.left), 64'hCC00CCFF);
        chk("ip right", 64'(dut.right), 64'hF0AAF0AA);
        step(); step();
        chk("k1 subkey", 64'(dut.subkey), 64'h1B02EFFC7072);
        step(); step();
        chk("r1 state", 64'(dut.state), 64'd6);
        chk("r1 feistel_out", 64'(dut.feistel_out), 64'h234AA9BB);
        step();
        chk("r1 right", 64'(dut.right), 64'hEF4A6544);
        finish_op("enc1", CT1);
        repeat (3) step();
        chk("hold done", 64'(done), 64'd1);
        chk("hold data_out", data_out, CT1);

        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("rst between data_out", data_out, 64'd0);
        launch(1'b0, CT1, K1);
        finish_op("dec1", PT1);

        // Second vector, decrypt restarted straight from DONE.
        launch(1'b1, PT2, K2);
        finish_op("enc2", 64'd0);
        launch(1'b0, 64'd0, K2);
        finish_op("dec2", PT2);

        // Start while busy, in the S-box cycle of round 3.
        launch(1'b1, PT1, K1);
        while (edge_n < 12) step();
        chk("busy state", 64'(dut.state), 64'd5);
        chk("busy round", 64'(dut.round_count), 64'd3);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("error pulse", 64'(error), 64'd1);
        step();
        chk("error cleared", 64'(error), 64'd0);
        finish_op("enc busy", CT1);

        // Asynchronous reset during round 8.
        launch(1'b1, PT2, K2);
        while (edge_n < 33) step();
        chk("mid round", 64'(dut.round_count), 64'd8);
        rst = 1'b1;
        #1;
        chk("async state", 64'(dut.state), 64'd0);
        chk("async done", 64'(done), 64'd0);
        chk("async data_out", data_out, 64'd0);
        chk("async left", 64'(dut.left), 64'd0);
        chk("async round", 64'(dut.round_count), 64'd0);
        @(negedge clk) rst = 1'b0;
        launch(1'b1, PT1, K1);
        finish_op("enc after rst", CT1);

        // Random blocks, keys and directions, each followed by the inverse operation.
        for (int n = 0; n < 8; n++) begin
            rk = {$urandom, $urandom};
            rp = {$urandom, $urandom};
            re = 1'($urandom_range(0, 1));
            rc = des_ref(rk, rp, re);
            launch(re, rp, rk);
            finish_op("rand fwd", rc);
            launch(~re, rc, rk);
            finish_op("rand inv", rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
